// File: rtl/congestion_detector_pkg.sv
// Shared definitions for the tunnel congestion detector.
package congestion_detector_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'b00,
    ST_PENDING   = 2'b01,
    ST_CONGESTED = 2'b10
  } cd_state_t;

endpackage

// File: rtl/congestion_detector_if.sv
// Sensor inputs and congestion/occupancy outputs of the detector.
interface congestion_detector_if #(
  parameter int CNT_W = 6
);
  logic             car_in;
  logic             car_out;
  logic             congestion;
  logic [CNT_W-1:0] occupancy;
  logic             overflow;
  logic             underflow;

  modport master (
    output car_in, car_out,
    input  congestion, occupancy, overflow, underflow
  );

  modport slave (
    input  car_in, car_out,
    output congestion, occupancy, overflow, underflow
  );
endinterface

// File: rtl/congestion_detector_sensor_sync_edge.sv
// Two-flop synchroniser for an asynchronous loop-sensor level, followed by a
// registered single-cycle pulse on each rising edge.
module sensor_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic sensor,
  output logic pulse
);
  logic sync1, sync2, sync2_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= sensor;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= sync2 & ~sync2_d;
    end
  end
endmodule

// File: rtl/congestion_detector.sv
// Tunnel occupancy counter with saturating count, sticky over/underflow flags
// and a hysteresis + hold-off congestion FSM.
//
// state        | meaning
// ST_CLEAR     | occupancy below arm threshold, congestion low
// ST_PENDING   | occupancy at/above HIGH_TH, counting hold-off cycles
// ST_CONGESTED | congestion asserted until occupancy drops to LOW_TH
module congestion_detector
  import congestion_detector_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int HIGH_TH     = 8,
  parameter int LOW_TH      = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  congestion_detector_if.slave  bus
);
  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] OCC_MAX   = '1;
  localparam logic [CNT_W-1:0] HIGH      = CNT_W'(HIGH_TH);
  localparam logic [CNT_W-1:0] LOW       = CNT_W'(LOW_TH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              in_pulse, out_pulse;
  logic [CNT_W-1:0]  occ;
  logic              overflow_q, underflow_q;
  cd_state_t         state, next_state;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              congestion_q, congestion_nxt;

  sensor_sync_edge u_sync_in (
    .clock   (clock),
    .reset_n (reset_n),
    .sensor  (bus.car_in),
    .pulse   (in_pulse)
  );

  sensor_sync_edge u_sync_out (
    .clock   (clock),
    .reset_n (reset_n),
    .sensor  (bus.car_out),
    .pulse   (out_pulse)
  );

  // Simultaneous entry and exit cancel; the count saturates at both ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (in_pulse && !out_pulse) begin
      if (occ == OCC_MAX) overflow_q <= 1'b1;
      else                occ        <= occ + CNT_W'(1);
    end else if (out_pulse && !in_pulse) begin
      if (occ == '0) underflow_q <= 1'b1;
      else           occ         <= occ - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CLEAR;
      hold_cnt     <= '0;
      congestion_q <= 1'b0;
    end else begin
      state        <= next_state;
      hold_cnt     <= hold_nxt;
      congestion_q <= congestion_nxt;
    end
  end

  always_comb begin
    next_state = state;
    hold_nxt   = hold_cnt;
    case (state)
      ST_CLEAR: begin
        if (occ >= HIGH) begin
          if (HOLD_CYCLES <= 1) begin
            next_state = ST_CONGESTED;
          end else begin
            next_state = ST_PENDING;
            hold_nxt   = HOLD_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (occ < HIGH) begin
          next_state = ST_CLEAR;
          hold_nxt   = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          next_state = ST_CONGESTED;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_CONGESTED: begin
        if (occ <= LOW) next_state = ST_CLEAR;
      end
      default: begin
        next_state = ST_CLEAR;
        hold_nxt   = '0;
      end
    endcase
  end

  // The flag is registered alongside the state, so it equals (state == CONGESTED).
  always_comb begin
    congestion_nxt = (next_state == ST_CONGESTED);
  end

  assign bus.congestion = congestion_q;
  assign bus.occupancy  = occ;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_congestion_detector.sv
// Directed, table-driven bench for congestion_detector at default parameters.
module tb_congestion_detector;
  localparam int CNT_W = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  congestion_detector_if #(.CNT_W(CNT_W)) bus ();

  congestion_detector #(
    .CNT_W       (CNT_W),
    .HIGH_TH     (8),
    .LOW_TH      (4),
    .HOLD_CYCLES (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int n_in;
    int n_out;
    int occ;
    int cong;
    int ovf;
    int unf;
  } vec_t;

  vec_t vt[9];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int occ, input int cong,
                           input int ovf, input int unf);
    check({tag, "_occ"},  32'(bus.occupancy),  occ);
    check({tag, "_cong"}, 32'(bus.congestion), cong);
    check({tag, "_ovf"},  32'(bus.overflow),   ovf);
    check({tag, "_unf"},  32'(bus.underflow),  unf);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enter(input int n);
    repeat (n) begin
      bus.car_in = 1'b1; tick();
      bus.car_in = 1'b0; tick();
    end
  endtask

  task automatic leave(input int n);
    repeat (n) begin
      bus.car_out = 1'b1; tick();
      bus.car_out = 1'b0; tick();
    end
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  task automatic do_reset();
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    reset_n     = 1'b0;
    tick(); tick();
    reset_n     = 1'b1;
    tick();
  endtask

  initial begin
    vt[0] = '{3, 0, 3, 0, 0, 0};
    vt[1] = '{5, 0, 8, 1, 0, 0};
    vt[2] = '{0, 2, 6, 1, 0, 0};
    vt[3] = '{0, 1, 5, 1, 0, 0};
    vt[4] = '{0, 1, 4, 0, 0, 0};
    vt[5] = '{4, 0, 8, 1, 0, 0};
    vt[6] = '{0, 4, 4, 0, 0, 0};
    vt[7] = '{0, 5, 0, 0, 0, 1};
    vt[8] = '{2, 0, 2, 0, 0, 1};

    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    reset_n     = 1'b0;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      enter(vt[i].n_in);
      leave(vt[i].n_out);
      settle();
      check_all($sformatf("vec%0d", i), vt[i].occ, vt[i].cong, vt[i].ovf, vt[i].unf);
    end

    // Reset mid-count with an entry edge still in the synchroniser.
    enter(3);
    settle();
    check_all("pre_rst", 5, 0, 0, 1);
    bus.car_in = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    bus.car_in = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    settle();
    check_all("post_rst", 0, 0, 0, 0);

    // Eighth car via a sensor held high for 20 cycles; exact congestion latency.
    enter(7);
    settle();
    check_all("hold_pre", 7, 0, 0, 0);
    bus.car_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("hold_k%0d_occ", k),  32'(bus.occupancy),  (k >= 4) ? 8 : 7);
      check($sformatf("hold_k%0d_cong", k), 32'(bus.congestion), (k >= 7) ? 1 : 0);
    end
    bus.car_in = 1'b0;
    settle();
    check_all("hold_once", 8, 1, 0, 0);

    // Exit lands during the hold-off window: back to CLEAR, never congested.
    do_reset();
    enter(7);
    settle();
    bus.car_in  = 1'b1; tick();
    bus.car_in  = 1'b0; tick();
    bus.car_out = 1'b1; tick();
    bus.car_out = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      tick();
      check($sformatf("pend_k%0d_occ", k),  32'(bus.occupancy),  (k >= 4 && k < 6) ? 8 : 7);
      check($sformatf("pend_k%0d_cong", k), 32'(bus.congestion), 0);
    end

    // Hysteresis: congested at 10, stays set down to 5, clears right after 4.
    enter(3);
    settle();
    check_all("hyst_10", 10, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      leave(1);
      settle();
      check($sformatf("hyst_occ%0d", 9 - i),  32'(bus.occupancy),  9 - i);
      check($sformatf("hyst_cong%0d", 9 - i), 32'(bus.congestion), 1);
    end
    bus.car_out = 1'b1; tick();
    bus.car_out = 1'b0; tick(); tick(); tick();
    check("hyst_k4_occ",  32'(bus.occupancy),  4);
    check("hyst_k4_cong", 32'(bus.congestion), 1);
    tick();
    check("hyst_k5_cong", 32'(bus.congestion), 0);

    // Entry and exit edges in the same cycle cancel.
    do_reset();
    enter(7);
    settle();
    bus.car_in  = 1'b1;
    bus.car_out = 1'b1;
    tick();
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    settle();
    check_all("same_cycle", 7, 0, 0, 0);

    // Saturation at both ends; flags are sticky.
    do_reset();
    leave(1);
    settle();
    check_all("unf", 0, 0, 0, 1);
    enter(64);
    settle();
    check_all("ovf", 63, 1, 1, 1);
    leave(1);
    settle();
    check_all("sticky", 62, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
